// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared definitions for the PWM generator / capture pair.
//   - pwm_cap_st_t : capture alignment state (SEARCH until the first rising
//                    edge is seen, LOCK afterwards).
//   - cnt_width()  : bit width of a window counter that runs 0..cce-1.
// -----------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } pwm_cap_st_t;

    // A counter spanning 0..cce-1 needs $clog2(cce) bits; never return zero
    // so that a 1-bit counter is still declared for the smallest window.
    function automatic int unsigned cnt_width(input int unsigned cce);
        int unsigned w;
        w = $clog2(cce);
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchronizer for a single asynchronous bit.
//
//   Ports
//     clk : destination clock
//     rst : asynchronous active-high reset, clears both flops
//     d   : asynchronous input bit
//     q   : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_cap.sv
// -----------------------------------------------------------------------------
// pwm_cap
//   Receive-side counterpart of the pwm generator. Samples an asynchronous
//   PWM/PDM line, aligns a CCE-cycle measurement window to the generator's
//   period using rising edges, and counts high samples per window. Every
//   window result is offered as one word on a single-entry valid/ready
//   output register.
//
//   Parameters
//     CCW : counter / output data width
//     CCE : window length in clocks and the 100% value (2 .. 2**CCW-1)
//     ECW : width of the saturating misalignment counter
//
//   Ports
//     clk     : system clock
//     rst     : asynchronous active-high reset
//     pwm     : PWM line, asynchronous to clk
//     str_dat : high-sample count of the last window, 0..CCE
//     str_vld : str_dat holds a word
//     str_rdy : downstream accepts the word this cycle
//     sts_lck : window is aligned to the PWM period
//     sts_ovf : sticky, a finished word was dropped (register was full)
//     sts_err : saturating count of rising edges seen off window position 0
//     ctl_clr : one-cycle pulse clearing sts_ovf and sts_err
// -----------------------------------------------------------------------------
module pwm_cap
    import pwm_pkg::*;
#(
    parameter int unsigned CCW = 4,
    parameter int unsigned CCE = 2**CCW - 1,
    parameter int unsigned ECW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pwm,
    output logic [CCW-1:0] str_dat,
    output logic           str_vld,
    input  logic           str_rdy,
    output logic           sts_lck,
    output logic           sts_ovf,
    output logic [ECW-1:0] sts_err,
    input  logic           ctl_clr
);

    localparam int unsigned    CNW      = cnt_width(CCE);
    localparam logic [CNW-1:0] CNT_LAST = CNW'(CCE - 1);
    localparam logic [ECW-1:0] ERR_MAX  = '1;

    // -------------------------------------------------------------------------
    // Input path: synchronizer, then one more register for edge detection.
    // -------------------------------------------------------------------------
    logic smp;
    logic pwm_d;
    logic rise;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pwm),
        .q   (smp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_d <= 1'b0;
        end else begin
            pwm_d <= smp;
        end
    end

    assign rise = smp & ~pwm_d;

    // -------------------------------------------------------------------------
    // Alignment FSM
    // -------------------------------------------------------------------------
    pwm_cap_st_t    state;
    pwm_cap_st_t    state_nxt;
    logic           realign;
    logic           misalign;

    logic [CNW-1:0] cnt;
    logic [CCW-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // realign: this cycle is treated as window position 0 and the partial
    // window gathered so far is thrown away. In LOCK a rise at position 0 is
    // the expected edge, so only off-position rises count as misalignment.
    always_comb begin
        state_nxt = state;
        realign   = 1'b0;
        misalign  = 1'b0;
        unique case (state)
            SEARCH: begin
                if (rise) begin
                    realign   = 1'b1;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (rise && (cnt != '0)) begin
                    realign  = 1'b1;
                    misalign = 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    assign sts_lck = (state == LOCK);

    // -------------------------------------------------------------------------
    // Window counter and accumulator
    // -------------------------------------------------------------------------
    logic [CNW-1:0] pos;
    logic [CNW-1:0] cnt_nxt;
    logic [CCW-1:0] sum;
    logic           evt;

    // pos is the effective window position of the current sample. Forcing it
    // to 0 on realign both restarts the accumulation with this sample and
    // suppresses the end-of-window event, which discards the partial window.
    always_comb begin
        pos = cnt;
        if (realign) begin
            pos = '0;
        end
        if (pos == '0) begin
            sum = CCW'(smp);
        end else begin
            sum = acc + CCW'(smp);
        end
        evt = (pos == CNT_LAST);
        if (evt) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = pos + CNW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else begin
            cnt <= cnt_nxt;
            acc <= sum;
        end
    end

    // -------------------------------------------------------------------------
    // Single-entry output register
    // -------------------------------------------------------------------------
    logic take;
    logic drop;

    // A word can be loaded when the register is empty or is being drained in
    // this same cycle; otherwise the new word is lost.
    assign take = evt & (~str_vld | str_rdy);
    assign drop = evt & str_vld & ~str_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            str_dat <= '0;
            str_vld <= 1'b0;
        end else begin
            if (take) begin
                str_dat <= sum;
                str_vld <= 1'b1;
            end else if (str_vld && str_rdy) begin
                str_vld <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status: a set or increment coinciding with ctl_clr takes priority, so the
    // event is never lost (ovf reads 1, err restarts from 1).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sts_ovf <= 1'b0;
        end else begin
            if (drop) begin
                sts_ovf <= 1'b1;
            end else if (ctl_clr) begin
                sts_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sts_err <= '0;
        end else begin
            if (misalign) begin
                if (ctl_clr) begin
                    sts_err <= ECW'(1);
                end else if (sts_err != ERR_MAX) begin
                    sts_err <= sts_err + ECW'(1);
                end
            end else if (ctl_clr) begin
                sts_err <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_cap.sv
module tb_pwm_cap;

    localparam int unsigned CCW = 4;
    localparam int unsigned CCE = 15;
    localparam int unsigned ECW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           pwm;
    logic [CCW-1:0] str_dat;
    logic           str_vld;
    logic           str_rdy;
    logic           sts_lck;
    logic           sts_ovf;
    logic [ECW-1:0] sts_err;
    logic           ctl_clr;

    pwm_cap #(.CCW(CCW), .CCE(CCE), .ECW(ECW)) dut (
        .clk     (clk),
        .rst     (rst),
        .pwm     (pwm),
        .str_dat (str_dat),
        .str_vld (str_vld),
        .str_rdy (str_rdy),
        .sts_lck (sts_lck),
        .sts_ovf (sts_ovf),
        .sts_err (sts_err),
        .ctl_clr (ctl_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference generator: a period of CCE cycles, high for the first v.
    // Every generator period after the first non-zero one must come back as
    // exactly one LOCK-state word equal to that period's value.
    int unsigned v_req;
    int unsigned cur_v;
    int unsigned gen_pos;
    int unsigned pause_left;
    bit          started;
    bit          const_mode;
    int unsigned const_v;
    int unsigned exp_q[$];
    int unsigned n_search;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic gen_reset();
        v_req      = 0;
        cur_v      = 0;
        gen_pos    = 0;
        pause_left = 0;
        started    = 1'b0;
        const_mode = 1'b0;
        const_v    = 0;
        exp_q.delete();
        pwm        = 1'b0;
    endtask

    // Called at a negedge: score the word about to be accepted at the next
    // posedge, drive the next line sample, then advance one clock.
    task automatic tick();
        if (str_vld && str_rdy && !rst) begin
            if (sts_lck) begin
                if (const_mode) begin
                    chk("lock_word_const", 32'(str_dat), const_v);
                end else begin
                    chk("lock_word_pending", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        chk("lock_word", 32'(str_dat), exp_q.pop_front());
                    end
                end
            end else begin
                n_search++;
                chk("search_word", 32'(str_dat), 0);
            end
        end
        if (rst) begin
            pwm = 1'b0;
        end else if (gen_pos == 0 && pause_left != 0) begin
            pwm = 1'b0;
            pause_left--;
        end else begin
            if (gen_pos == 0) begin
                cur_v = v_req;
                if (cur_v != 0) started = 1'b1;
                if (started) exp_q.push_back(cur_v);
            end
            pwm     = (gen_pos < cur_v);
            gen_pos = (gen_pos == CCE - 1) ? 0 : gen_pos + 1;
        end
        @(negedge clk);
    endtask

    task automatic run_periods(input int unsigned v, input int unsigned n);
        v_req = v;
        repeat (n * CCE) tick();
    endtask

    task automatic wait_vld(input string tag);
        for (int i = 0; i < 3 * CCE && !str_vld; i++) tick();
        chk(tag, 32'(str_vld), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CCW-1:0] held;
        int unsigned    k;
        int unsigned    v;

        n_search = 0;
        rst      = 1'b1;
        str_rdy  = 1'b1;
        ctl_clr  = 1'b0;
        gen_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_dat", 32'(str_dat), 0);
        chk("rst_vld", 32'(str_vld), 0);
        chk("rst_lck", 32'(sts_lck), 0);
        chk("rst_ovf", 32'(sts_ovf), 0);
        chk("rst_err", 32'(sts_err), 0);
        rst = 1'b0;

        // Constant 0 from reset: SEARCH words of 0, then lock on value 7.
        run_periods(0, 4);
        chk("const0_no_lock", 32'(sts_lck), 0);
        chk("const0_words_seen", 32'(n_search >= 3), 1);
        v_req = 7;
        for (int i = 0; i < 4 * CCE && !sts_lck; i++) tick();
        chk("lock_acquire", 32'(sts_lck), 1);
        run_periods(7, 3);

        // Ordered sweep, then random values with random hold lengths.
        for (int unsigned s = 0; s <= CCE; s++) run_periods(s, 3);
        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(0, CCE);
            run_periods(v, $urandom_range(1, 3));
        end
        chk("sweep_lck", 32'(sts_lck), 1);
        chk("sweep_err", 32'(sts_err), 0);
        chk("sweep_ovf", 32'(sts_ovf), 0);
        chk("sweep_drain", 32'(exp_q.size() <= 2), 1);

        // 100% after lock on 5: no edges, lock held, full-scale words.
        run_periods(5, 3);
        run_periods(CCE, 4);
        chk("full_lck", 32'(sts_lck), 1);
        chk("full_err", 32'(sts_err), 0);

        // Phase jump: line delayed by 6 cycles while carrying value 9.
        run_periods(9, 3);
        pause_left = 6;
        run_periods(9, 5);
        chk("jump_err", 32'(sts_err), 1);
        chk("jump_lck", 32'(sts_lck), 1);
        chk("jump_drain", 32'(exp_q.size() <= 2), 1);

        // Short stalls of up to CCE-1 cycles lose nothing.
        for (int n = 0; n < 4; n++) begin
            v_req   = $urandom_range(0, CCE);
            k       = $urandom_range(1, CCE - 1);
            str_rdy = 1'b0;
            wait_vld("stall_wait_vld");
            held = str_dat;
            for (int unsigned i = 1; i < k; i++) begin
                tick();
                chk("stall_hold", 32'(str_dat), 32'(held));
            end
            str_rdy = 1'b1;
            repeat (2 * CCE) tick();
            chk("stall_no_ovf", 32'(sts_ovf), 0);
        end
        chk("stall_drain", 32'(exp_q.size() <= 2), 1);

        // Long backpressure on value 4: held word stable, later words dropped.
        run_periods(4, 3);
        const_mode = 1'b1;
        const_v    = 4;
        str_rdy    = 1'b0;
        wait_vld("bp_wait_vld");
        held = str_dat;
        chk("bp_first_word", 32'(held), 4);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("bp_hold_vld", 32'(str_vld), 1);
            chk("bp_hold_dat", 32'(str_dat), 32'(held));
        end
        chk("bp_ovf_set", 32'(sts_ovf), 1);
        str_rdy = 1'b1;
        ctl_clr = 1'b1;
        tick();
        ctl_clr = 1'b0;
        chk("clr_ovf", 32'(sts_ovf), 0);
        chk("clr_err", 32'(sts_err), 0);
        run_periods(4, 2);
        chk("post_clr_ovf", 32'(sts_ovf), 0);

        // Reset while a word is held: everything clears asynchronously.
        str_rdy = 1'b0;
        wait_vld("rst_wait_vld");
        #1 rst = 1'b1;
        #1;
        chk("midrst_dat", 32'(str_dat), 0);
        chk("midrst_vld", 32'(str_vld), 0);
        chk("midrst_lck", 32'(sts_lck), 0);
        chk("midrst_ovf", 32'(sts_ovf), 0);
        chk("midrst_err", 32'(sts_err), 0);
        gen_reset();
        str_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("post_rst_no_vld", 32'(str_vld), 0);
        end
        run_periods(0, 2);
        chk("post_rst_search", 32'(sts_lck), 0);
        run_periods($urandom_range(1, CCE), 2);
        for (int i = 0; i < 6; i++) run_periods($urandom_range(0, CCE), 2);
        chk("resume_lck", 32'(sts_lck), 1);
        chk("resume_err", 32'(sts_err), 0);
        chk("resume_drain", 32'(exp_q.size() <= 2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
